// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter and its clients.
package alu_pkg;

   localparam int unsigned Bits   = 5;
   localparam int unsigned FlagW  = 4;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   // Operation held on the ALU inputs
   typedef struct packed {
      alu_op_t         op;
      logic [Bits-1:0] a;
      logic [Bits-1:0] b;
   } alu_req_t;

   // Result captured from the ALU and returned to the owner
   typedef struct packed {
      logic [Bits-1:0]  result;
      logic [FlagW-1:0] flags;
   } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_arbiter.
interface alu_arbiter_if;
   import alu_pkg::*;

   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [Bits-1:0]  req_a0;
   logic [Bits-1:0]  req_b0;
   logic [Bits-1:0]  req_a1;
   logic [Bits-1:0]  req_b1;
   logic [1:0]       req_op0;
   logic [1:0]       req_op1;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [Bits-1:0]  rsp_result;
   logic [FlagW-1:0] rsp_flags;
   logic [Bits-1:0]  alu_a;
   logic [Bits-1:0]  alu_b;
   logic [1:0]       alu_ctrl;
   logic [Bits-1:0]  alu_result;
   logic [FlagW-1:0] alu_flags;
   logic             busy;

   modport master (
      output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
      output rsp_ready, alu_result, alu_flags,
      input  req_ready, rsp_valid, rsp_result, rsp_flags,
      input  alu_a, alu_b, alu_ctrl, busy
   );

   modport slave (
      input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
      input  rsp_ready, alu_result, alu_flags,
      output req_ready, rsp_valid, rsp_result, rsp_flags,
      output alu_a, alu_b, alu_ctrl, busy
   );

endinterface

// File: rtl/alu_arbiter_rr_grant2.sv
// Two-way round-robin grant: a lone requester wins, contention goes to
// the requester that was not granted last.
module rr_grant2 (
   input  logic [1:0] req_valid,
   input  logic       last_grant,
   output logic       grant,
   output logic       any_valid
);

   always_comb begin
      any_valid = |req_valid;
      grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: accept, drive the ALU for
// one cycle, capture its result and hand it back to the granted requester.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);

   arb_state_t state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic       owner_q, owner_d;
   alu_req_t   op_q, op_d;
   alu_rsp_t   rsp_q, rsp_d;
   logic [1:0] rsp_valid_q, rsp_valid_d;
   logic       busy_q, busy_d;
   logic [1:0] req_ready_c;
   logic       grant;
   logic       any_valid;
   alu_req_t   req_sel;

   rr_grant2 u_grant (
      .req_valid  (bus.req_valid),
      .last_grant (last_grant_q),
      .grant      (grant),
      .any_valid  (any_valid)
   );

   // Operands of whichever requester the arbiter is currently offering to
   always_comb begin
      req_sel.op = alu_op_t'(grant ? bus.req_op1 : bus.req_op0);
      req_sel.a  = grant ? bus.req_a1 : bus.req_a0;
      req_sel.b  = grant ? bus.req_b1 : bus.req_b0;
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      op_d         = op_q;
      rsp_d        = rsp_q;
      req_ready_c  = 2'b00;

      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               req_ready_c[grant] = 1'b1;
               op_d               = req_sel;
               owner_d            = grant;
               last_grant_d       = grant;
               state_d            = EXEC;
            end
         end
         EXEC: begin
            rsp_d.result = bus.alu_result;
            rsp_d.flags  = bus.alu_flags;
            state_d      = RESP;
         end
         RESP: begin
            if (bus.rsp_ready[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Response valid is a registered decode of the next state
      rsp_valid_d = (state_d == RESP) ? {owner_d, ~owner_d} : 2'b00;
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         op_q         <= '{op: OP_ADD, a: '0, b: '0};
         rsp_q        <= '0;
         rsp_valid_q  <= 2'b00;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         op_q         <= op_d;
         rsp_q        <= rsp_d;
         rsp_valid_q  <= rsp_valid_d;
         busy_q       <= busy_d;
      end
   end

   // Nothing is offered while reset is held
   assign bus.req_ready  = req_ready_c & {2{rst_n}};
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_q.result;
   assign bus.rsp_flags  = rsp_q.flags;
   assign bus.alu_a      = op_q.a;
   assign bus.alu_b      = op_q.b;
   assign bus.alu_ctrl   = op_q.op;
   assign bus.busy       = busy_q;

endmodule
